// File: rtl/mul_result_stage.sv
// Final multiply stage: registers the CSA tree's sum/carry pair, does the carry-propagate
// add, picks the low or high word and buffers results in a 2-entry queue toward writeback.
module mul_result_stage #(
  parameter int WORD_WIDTH            = 32,
  parameter int PARTIAL_PRODUCT_WIDTH = 2 * (WORD_WIDTH + 1),
  parameter int ROB_TAG_WIDTH         = 5,
  parameter int PREG_WIDTH            = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PARTIAL_PRODUCT_WIDTH-1:0] mul_add_a,
  input  logic [PARTIAL_PRODUCT_WIDTH-1:0] mul_add_b,
  input  logic                             in_hi,
  input  logic [ROB_TAG_WIDTH-1:0]         in_rob_tag,
  input  logic [PREG_WIDTH-1:0]            in_preg,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH-1:0]            out_data,
  output logic [ROB_TAG_WIDTH-1:0]         out_rob_tag,
  output logic [PREG_WIDTH-1:0]            out_preg
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid must not
  // depend on ready, and the producer holds its payload stable until the transfer.

  logic                             s1_valid_q, s1_valid_d;
  logic [PARTIAL_PRODUCT_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [PARTIAL_PRODUCT_WIDTH-1:0] s1_b_q, s1_b_d;
  logic                             s1_hi_q, s1_hi_d;
  logic [ROB_TAG_WIDTH-1:0]         s1_tag_q, s1_tag_d;
  logic [PREG_WIDTH-1:0]            s1_preg_q, s1_preg_d;

  logic [1:0][WORD_WIDTH-1:0]       q_data_q, q_data_d;
  logic [1:0][ROB_TAG_WIDTH-1:0]    q_tag_q, q_tag_d;
  logic [1:0][PREG_WIDTH-1:0]       q_preg_q, q_preg_d;
  logic                             wr_ptr_q, wr_ptr_d;
  logic                             rd_ptr_q, rd_ptr_d;
  logic [1:0]                       count_q, count_d;

  logic [PARTIAL_PRODUCT_WIDTH-1:0] sum;
  logic [WORD_WIDTH-1:0]            result;
  logic                             unused_sum_top;
  logic                             pop;
  logic                             drain;
  logic                             accept;

  // Carry out of the top bit and product bits above 63 are architecturally meaningless.
  assign sum            = s1_a_q + s1_b_q;
  assign result         = s1_hi_q ? sum[2*WORD_WIDTH-1:WORD_WIDTH] : sum[WORD_WIDTH-1:0];
  assign unused_sum_top = ^sum[PARTIAL_PRODUCT_WIDTH-1:2*WORD_WIDTH];

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign drain     = s1_valid_q && ((count_q < 2'd2) || pop);
  assign in_ready  = !flush && (!s1_valid_q || drain);
  assign accept    = in_valid && in_ready;

  // Gating with out_valid keeps the result bus quiet while the queue is empty.
  assign out_data    = out_valid ? q_data_q[rd_ptr_q] : '0;
  assign out_rob_tag = out_valid ? q_tag_q[rd_ptr_q]  : '0;
  assign out_preg    = out_valid ? q_preg_q[rd_ptr_q] : '0;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_hi_d    = s1_hi_q;
    s1_tag_d   = s1_tag_q;
    s1_preg_d  = s1_preg_q;
    q_data_d   = q_data_q;
    q_tag_d    = q_tag_q;
    q_preg_d   = q_preg_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, drain} - {1'b0, pop};

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = mul_add_a;
      s1_b_d     = mul_add_b;
      s1_hi_d    = in_hi;
      s1_tag_d   = in_rob_tag;
      s1_preg_d  = in_preg;
    end else if (drain) begin
      s1_valid_d = 1'b0;
    end

    if (drain) begin
      q_data_d[wr_ptr_q] = result;
      q_tag_d[wr_ptr_q]  = s1_tag_q;
      q_preg_d[wr_ptr_q] = s1_preg_q;
      wr_ptr_d           = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Flush wins over every handshake in its cycle; a popped head is simply dropped.
    if (flush) begin
      s1_valid_d = 1'b0;
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_hi_q    <= 1'b0;
      s1_tag_q   <= '0;
      s1_preg_q  <= '0;
      q_data_q   <= '0;
      q_tag_q    <= '0;
      q_preg_q   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_hi_q    <= s1_hi_d;
      s1_tag_q   <= s1_tag_d;
      s1_preg_q  <= s1_preg_d;
      q_data_q   <= q_data_d;
      q_tag_q    <= q_tag_d;
      q_preg_q   <= q_preg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_mul_result_stage.sv
// Bench for mul_result_stage: fixed vectors, backpressure/flush/reset sequences and a
// randomized run scored against an arithmetic reference and an in-order expected queue.
module tb_mul_result_stage;
  localparam int W   = 32;
  localparam int PW  = 66;
  localparam int TW  = 5;
  localparam int PRW = 6;
  localparam int EW  = W + TW + PRW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] mul_add_a;
  logic [PW-1:0] mul_add_b;
  logic          in_hi;
  logic [TW-1:0] in_rob_tag;
  logic [PRW-1:0] in_preg;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_rob_tag;
  logic [PRW-1:0] out_preg;

  mul_result_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mul_add_a   (mul_add_a),
    .mul_add_b   (mul_add_b),
    .in_hi       (in_hi),
    .in_rob_tag  (in_rob_tag),
    .in_preg     (in_preg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rob_tag (out_rob_tag),
    .out_preg    (out_preg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out   = '0;
  logic          last_ov    = 1'b0;
  logic          last_ir    = 1'b0;
  logic [EW-1:0] last_out   = '0;

  typedef struct {
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic          hi;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[8];

  // Reference: full-width sum modulo 2^66, then pick the requested 32-bit word.
  function automatic logic [W-1:0] ref_result(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                              input logic hi);
    logic [PW-1:0] s;
    s = a + b;
    if (hi) return W'(s >> 32);
    return W'(s);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs just after a rising edge, check and score at the falling edge.
  task automatic drive(input logic v, input logic [PW-1:0] a, input logic [PW-1:0] b,
                       input logic hi, input logic [TW-1:0] tag, input logic [PRW-1:0] preg,
                       input logic ordy, input logic fl);
    logic [EW-1:0] cur;
    in_valid   = v;
    mul_add_a  = a;
    mul_add_b  = b;
    in_hi      = hi;
    in_rob_tag = tag;
    in_preg    = preg;
    out_ready  = ordy;
    flush      = fl;
    @(negedge clk);
    cur = {out_data, out_rob_tag, out_preg};
    chk("in_ready", {63'd0, in_ready}, {63'd0, !fl && (exp_q.size() < 3 || ordy)});
    if (exp_q.size() == 0) chk("out_valid_when_empty", {63'd0, out_valid}, 64'd0);
    if (prev_stall) chk("stall_hold", {21'd0, cur}, {21'd0, prev_out});
    if (out_valid && ordy && exp_q.size() != 0) begin
      chk("pop_entry", {21'd0, cur}, {21'd0, exp_q[0]});
      void'(exp_q.pop_front());
    end
    if (v && in_ready) exp_q.push_back({ref_result(a, b, hi), tag, preg});
    if (fl) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      prev_stall = out_valid && !ordy;
    end
    prev_out = cur;
    last_ov  = out_valid;
    last_ir  = in_ready;
    last_out = cur;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mul_add_a = '0;
    mul_add_b = '0;
    in_hi     = 1'b0;
    in_rob_tag = '0;
    in_preg   = '0;
    exp_q.delete();
    prev_stall = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PW-1:0] ra, rb;

    vecs[0] = '{66'd20, 66'd15, 1'b0, 32'h0000_0023};
    vecs[1] = '{{PW{1'b1}}, 66'd0, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{66'd1 << 40, 66'd1 << 40, 1'b1, 32'h0000_0200};
    vecs[3] = '{66'd1 << 40, 66'd1 << 40, 1'b0, 32'h0000_0000};
    vecs[4] = '{66'd1 << 65, 66'd1 << 65, 1'b0, 32'h0000_0000};
    vecs[5] = '{66'd1 << 65, 66'd1 << 65, 1'b1, 32'h0000_0000};
    vecs[6] = '{66'h0_FFFF_FFFF, 66'd1, 1'b1, 32'h0000_0001};
    vecs[7] = '{66'h3_0000_0001_0000_0000, 66'h0_0000_0001_0000_0000, 1'b1, 32'h0000_0002};

    // Reset values
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {32'd0, out_data}, 64'd0);
    chk("reset_out_tag", {59'd0, out_rob_tag}, 64'd0);
    chk("reset_out_preg", {58'd0, out_preg}, 64'd0);
    apply_reset();
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Table vectors, one at a time, with the two-cycle latency checked
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].hi, TW'(i + 1), PRW'(40 + i), 1'b0, 1'b0);
      idle(1'b0);
      chk("latency_n1_not_valid", {63'd0, last_ov}, 64'd0);
      idle(1'b1);
      chk("latency_n2_valid", {63'd0, last_ov}, 64'd1);
      chk("vec_data", {32'd0, last_out[EW-1:TW+PRW]}, {32'd0, vecs[i].exp});
      chk("vec_tag", {59'd0, last_out[TW+PRW-1:PRW]}, 64'(i + 1));
      chk("vec_preg", {58'd0, last_out[PRW-1:0]}, 64'(40 + i));
    end

    // Backpressure: four back-to-back pairs against a stalled consumer
    for (int t = 1; t <= 3; t++) begin
      ra = PW'({$urandom, $urandom, $urandom});
      rb = PW'({$urandom, $urandom, $urandom});
      drive(1'b1, ra, rb, t[0], TW'(t), PRW'(t), 1'b0, 1'b0);
      chk("bp_accept", {63'd0, last_ir}, 64'd1);
    end
    ra = PW'({$urandom, $urandom, $urandom});
    rb = PW'({$urandom, $urandom, $urandom});
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, ra, rb, 1'b1, TW'(4), PRW'(4), 1'b0, 1'b0);
      chk("bp_full_in_ready", {63'd0, last_ir}, 64'd0);
    end
    // Pop, drain and accept together while the queue is full
    drive(1'b1, ra, rb, 1'b1, TW'(4), PRW'(4), 1'b1, 1'b0);
    chk("full_pushpop_in_ready", {63'd0, last_ir}, 64'd1);
    chk("bp_order_tag1", {59'd0, last_out[TW+PRW-1:PRW]}, 64'd1);
    for (int t = 2; t <= 4; t++) begin
      idle(1'b1);
      chk("bp_consecutive_valid", {63'd0, last_ov}, 64'd1);
      chk("bp_order_tag", {59'd0, last_out[TW+PRW-1:PRW]}, 64'(t));
    end
    idle(1'b1);

    // Flush with three in flight and a pair offered in the flush cycle
    for (int t = 11; t <= 13; t++) begin
      ra = PW'({$urandom, $urandom, $urandom});
      drive(1'b1, ra, PW'(t), 1'b0, TW'(t), PRW'(t), 1'b0, 1'b0);
    end
    drive(1'b1, 66'd7, 66'd7, 1'b0, TW'(14), PRW'(14), 1'b1, 1'b1);
    chk("flush_cycle_in_ready", {63'd0, last_ir}, 64'd0);
    idle(1'b1);
    chk("after_flush_out_valid", {63'd0, last_ov}, 64'd0);
    chk("after_flush_in_ready", {63'd0, last_ir}, 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-cycle with three in flight
    for (int t = 21; t <= 23; t++) begin
      ra = PW'({$urandom, $urandom, $urandom});
      drive(1'b1, ra, PW'(t), 1'b1, TW'(t), PRW'(t), 1'b0, 1'b0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_out_data", {32'd0, out_data}, 64'd0);
    chk("async_rst_out_tag", {59'd0, out_rob_tag}, 64'd0);
    chk("async_rst_out_preg", {58'd0, out_preg}, 64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("post_rst_no_output", {63'd0, last_ov}, 64'd0);
    end

    // Randomized traffic with occasional flush
    for (int k = 0; k < 400; k++) begin
      ra = PW'({$urandom, $urandom, $urandom});
      rb = PW'({$urandom, $urandom, $urandom});
      drive(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
            TW'($urandom), PRW'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0);
    end
    for (int k = 0; k < 10; k++) idle(1'b1);
    chk("drain_all_results", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_result_stage.md
Name: mul_result_stage

Overview:
- Final stage of the multiply unit, directly downstream of the Wallace CSA tree.
- Registers the tree's redundant sum/carry pair with its instruction metadata, then performs the final carry-propagate add and selects the low or high result word.
- Buffers results in a 2-entry output queue toward the writeback/CDB arbiter, with valid/ready backpressure on both sides and pipeline flush.

Parameters:
- WORD_WIDTH, 32, architectural result width.
- PARTIAL_PRODUCT_WIDTH, 2*(WORD_WIDTH+1) = 66, width of the tree sum/carry vectors.
- ROB_TAG_WIDTH, 5, reorder-buffer tag width.
- PREG_WIDTH, 6, physical destination register tag width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight work.
- in_valid  in  1  tree output pair valid.
- in_ready  out  1  stage can accept a pair this cycle.
- mul_add_a  in  PARTIAL_PRODUCT_WIDTH  tree sum vector.
- mul_add_b  in  PARTIAL_PRODUCT_WIDTH  tree carry vector.
- in_hi  in  1  1 = return product[63:32] (MULH/MULHSU/MULHU); 0 = return product[31:0] (MUL).
- in_rob_tag  in  ROB_TAG_WIDTH  ROB tag.
- in_preg  in  PREG_WIDTH  destination physical register.
- out_valid  out  1  result available at queue head.
- out_ready  in  1  writeback accepts the head this cycle.
- out_data  out  WORD_WIDTH  selected result word.
- out_rob_tag  out  ROB_TAG_WIDTH  tag of the head entry.
- out_preg  out  PREG_WIDTH  preg of the head entry.

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0; queue count=0; read/write pointers=0; all data/tag registers cleared. out_valid=0, out_data=0, out_rob_tag=0, out_preg=0. in_ready=1 once rst_n deasserts.
- Accept: transfer occurs when in_valid && in_ready. The transfer loads S1 with a, b, hi, rob_tag and preg, and sets s1_valid.
- Add/select, combinational from S1:
  - sum = (s1_a + s1_b) mod 2^66, with carry out of bit 65 discarded.
  - result = s1_hi ? sum[63:32] : sum[31:0]. Bits 65:64 are ignored.
- S1 drain: s1_drain = s1_valid && (count<2 || (out_valid && out_ready)). On drain, result and metadata are written at the write pointer.
- in_ready = !flush && (!s1_valid || s1_drain). The stage accepts a new pair in the same cycle S1 drains.
- Queue:
  - 2 entries, FIFO order.
  - Pop = out_valid && out_ready. Push and pop may occur in the same cycle, including when count=2.
  - Count never exceeds 2. Pointers wrap 1→0.
- Outputs: out_valid = (count!=0). out_data/out_rob_tag/out_preg come from the head entry and hold stable while out_valid && !out_ready.
- Latency: pair accepted at edge N → in S1 during cycle N+1 → queued at edge N+1 → out_valid in cycle N+2 (queue empty, no backpressure). Throughput 1/cycle with out_ready held high.
- Capacity: 3 in flight (S1 + 2 queue entries). With the queue full and no pop, S1 holds and in_ready=0.
- Flush (sampled on the clock edge):
  - Clears s1_valid, count and both pointers.
  - in_valid is ignored that cycle, since in_ready is forced to 0.
  - A pop handshake in the flush cycle is still honoured by the consumer, but the entry is discarded regardless.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-operation: all in-flight results are lost, with no output glitch after release.

Test Plan:
- Basic low word: a=66'd20, b=66'd15, hi=0, out_ready=1, accept at edge N → out_valid in cycle N+2, out_data=0x00000023, tags echoed unchanged.
- High word / sign: a=66 bits all ones, b=0, hi=1 → out_data=0xFFFFFFFF. Then a=2^40, b=2^40, hi=1 → out_data=0x00000200. Then a=2^40, b=2^40, hi=0 → out_data=0x00000000.
- Wrap discard: a=2^65, b=2^65 (sum=2^66), hi=0 and hi=1 → out_data=0 both cases.
- Backpressure/order:
  - Hold out_ready=0 and drive 4 back-to-back pairs with rob_tag 1..4 → 3 accepted; in_ready=0 from the cycle the 4th is presented.
  - Raise out_ready → outputs appear with tags 1,2,3, then 4 once accepted, on consecutive cycles.
  - out_data is stable while stalled.
- Simultaneous push/pop at full: count=2, S1 valid, out_ready=1 → pop, drain and new accept all in one cycle; count stays 2; in_ready=1.
- Flush and reset:
  - With 3 in flight, assert flush for 1 cycle while in_valid=1 → next cycle out_valid=0, nothing from before the flush appears, the flush-cycle pair is not accepted.
  - Repeat with rst_n pulsed low asynchronously mid-cycle → outputs go to 0 immediately.
